// File: rtl/adpll_nco_core.sv
// adpll_nco_core: all-digital PLL core with a phase-accumulator NCO and a PI loop filter. The lock detector exists only when ADPLL_LOCK_DETECT_EN is defined.
// Ports: clk, rst_n (sync, active-low), ena (run enable), ref_in (async reference),
//        dco_out (acc[15]), fcw (frequency word), phase_err (signed error at last edge),
//        ref_edge (accepted-edge pulse), lock (lock indicator; tied 0 without ADPLL_LOCK_DETECT_EN).
module adpll_nco_core #(
  parameter logic [15:0] FCW_INIT = 16'h0100,
  parameter int KP_SHIFT = 2,
  parameter int KI_SHIFT = 5,
  parameter int LOCK_TOL = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic        ref_in,
  output logic        dco_out,
  output logic [15:0] fcw,
  output logic [7:0]  phase_err,
  output logic        ref_edge,
  output logic        lock
);
  logic s1, s2, hist, edge_ok;
  logic [15:0] acc, fcw_nxt;
  logic signed [15:0] integ, integ_nxt;
  logic signed [16:0] sum;
  logic signed [17:0] integ_x, err_x, fcw_raw;
  always_comb begin
    edge_ok = s2 & ~hist & ena;
    sum = $signed({integ[15], integ}) + $signed({{9{acc[15]}}, acc[15:8]});
    integ_nxt = sum > 17'sd16383 ? 16'sh3FFF : sum < -17'sd16383 ? 16'shC001 : sum[15:0];
    integ_x = $signed({{2{integ_nxt[15]}}, integ_nxt});
    err_x = $signed({{10{acc[15]}}, acc[15:8]});
    fcw_raw = $signed({2'b00, FCW_INIT}) - (integ_x >>> KI_SHIFT) - (err_x >>> KP_SHIFT);
    fcw_nxt = fcw_raw < 18'sd1 ? 16'h0001 : fcw_raw > 18'sd32767 ? 16'h7FFF : fcw_raw[15:0];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      {s1, s2, hist} <= 3'b000;
      acc <= 16'h0000;
      fcw <= FCW_INIT;
      integ <= 16'sh0000;
      phase_err <= 8'h00;
      ref_edge <= 1'b0;
    end else begin
      s1 <= ref_in;
      s2 <= s1;
      hist <= s2;
      ref_edge <= edge_ok;
      if (ena) acc <= acc + fcw;
      if (edge_ok) begin
        phase_err <= acc[15:8];
        integ <= integ_nxt;
        fcw <= fcw_nxt;
      end
    end
  end
  assign dco_out = acc[15];
`ifdef ADPLL_LOCK_DETECT_EN
  logic [2:0] lock_cnt;
  logic [7:0] err_mag;
  // magnitude kept unsigned so -128 reads as 128 and never falls inside the window
  assign err_mag = acc[15] ? ~acc[15:8] + 8'd1 : acc[15:8];
  always_ff @(posedge clk) begin
    if (!rst_n || !ena) lock_cnt <= 3'd0;
    else if (edge_ok) lock_cnt <= err_mag <= 8'(LOCK_TOL) ? (&lock_cnt ? lock_cnt : lock_cnt + 3'd1) : 3'd0;
  end
  assign lock = &lock_cnt;
`else
  logic tol_unused;
  assign tol_unused = ^LOCK_TOL;
  assign lock = 1'b0;
`endif
endmodule

// File: doc/adpll_nco_core.md
ADPLL_NCO_CORE -- requirements
Module: adpll_nco_core

Interface
REQ-001 SHALL have parameter FCW_INIT, 16'h0100, free-running frequency control word at reset.
REQ-002 SHALL have parameter KP_SHIFT, 2, proportional-path arithmetic right shift.
REQ-003 SHALL have parameter KI_SHIFT, 5, integral-path arithmetic right shift.
REQ-004 SHALL have parameter LOCK_TOL, 4, lock window: absolute phase error <= LOCK_TOL.
REQ-005 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-007 SHALL have port ena  input  1  run enable; low freezes the loop.
REQ-008 SHALL have port ref_in  input  1  asynchronous reference pulse train.
REQ-009 SHALL have port dco_out  output  1  NCO square output, acc[15].
REQ-010 SHALL have port fcw  output  16  current frequency control word.
REQ-011 SHALL have port phase_err  output  8  signed phase error captured at last reference edge.
REQ-012 SHALL have port ref_edge  output  1  one-cycle pulse on each accepted reference edge.
REQ-013 SHALL have port lock  output  1  lock indicator.

Function
REQ-014 SHALL synchronise ref_in through two flops plus one history flop; edge = sync2 & ~hist, asserted 2 clk after a clean ref_in rise.
REQ-015 SHALL add fcw to 16-bit phase accumulator acc every cycle ena=1, modulo 2^16 wrap, no carry out.
REQ-016 SHALL, on edge with ena=1, capture err = acc[15:8] as signed 8-bit (acc value before that cycle's add) into phase_err, and pulse ref_edge.
REQ-017 SHALL, same cycle, update integ (16-bit signed) to integ+err, saturating at +/-16'h3FFF.
REQ-018 SHALL, same cycle, set fcw = FCW_INIT - (integ_new >>> KI_SHIFT) - (err >>> KP_SHIFT), computed at 18 bits signed, clamped to [16'h0001, 16'h7FFF]; new fcw used by acc from next cycle.
REQ-019 SHALL, when ena=0, hold acc, fcw, integ, phase_err, ignore edges (ref_edge=0), clear lock counter; synchroniser keeps running so no stale edge fires on ena rising.
REQ-020 SHALL treat edge and ena=0 in the same cycle as no edge.
REQ-021 SHALL keep 3-bit lock counter: on accepted edge, increment (saturate at 7) if |err| <= LOCK_TOL, else clear; lock=1 while counter==7 and cleared same cycle counter clears (err=-128 counts as magnitude 128).

Reset
REQ-022 SHALL, on clk rising with rst_n=0, set acc=0, fcw=FCW_INIT, integ=0, phase_err=0, ref_edge=0, lock=0, lock counter=0, synchroniser flops=0; dco_out therefore 0.
REQ-023 SHALL abandon any in-progress update when reset asserts mid-operation; first post-reset edge needs ref_in low-then-high after synchroniser clears.

Configuration
REQ-024 SHALL compile lock counter and LOCK_TOL comparison only when macro ADPLL_LOCK_DETECT_EN is defined; undefined: lock tied 0, counter absent, loop behaviour otherwise identical.

Verification
REQ-025 SHALL check reset: rst_n low 2 clk -> fcw=0x0100, dco_out=0, lock=0, phase_err=0; then ena=1, no ref -> dco_out toggles every 128 clk.
REQ-026 SHALL check positive error: one edge with acc[15:8]=0x10 -> phase_err=0x10, integ=16, fcw=0x00FC next cycle.
REQ-027 SHALL check negative error: first edge with acc[15:8]=0x80 -> phase_err=0x80 (-128), fcw=0x0124.
REQ-028 SHALL check lock: ref period 256 clk aligned so err=0 -> lock=1 on 7th accepted edge; one edge with err=+8 -> lock=0 same cycle.
REQ-029 SHALL check saturation: repeated err=+127 edges -> integ stops at 0x3FFF, fcw clamps at 0x0001, never wraps.
REQ-030 SHALL check ena freeze and mid-run reset: ena=0 with ref pulses -> acc/fcw constant, ref_edge=0, lock=0; rst_n low mid-run -> all REQ-022 values next cycle.
